bank_xbar_pipe: RTL and testbench
=================================

Name: bank_xbar_pipe

Overview:
- Parametrised, pipelined lane-to-bank crossbar for the multi-bank coefficient memory of the NTT datapath.
- Each butterfly lane presents an address, a target bank index and write data. The block routes each lane to its bank's port with registered outputs.
- It tracks the routing through the BRAM read latency and returns read data to the originating lanes.
- It detects bank conflicts, resolves them, and counts them.
- One instance serves one BRAM port; dual-port memories use two instances.

Parameters:
- LANES, 8, number of lanes and number of banks (power of 2, >=2).
- ADW, 5, per-bank address width.
- DW, 32, coefficient data width.
- RD_LAT, 2, BRAM read latency in cycles from bank_en to valid bank_rdata (>=1).
- LW, $clog2(LANES), bank index width (localparam, not overridable).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  lane request vector valid this cycle.
- in_we  in  1  1 = write transaction, 0 = read transaction (applies to all lanes).
- lane_addr  in  LANES*ADW  per-lane bank address; lane l occupies bits [l*ADW +: ADW].
- lane_bank  in  LANES*LW  per-lane target bank index.
- lane_wdata  in  LANES*DW  per-lane write data.
- bank_en  out  LANES  per-bank port enable.
- bank_we  out  LANES  per-bank write enable.
- bank_addr  out  LANES*ADW  per-bank address.
- bank_wdata  out  LANES*DW  per-bank write data.
- bank_rdata  in  LANES*DW  per-bank read data from BRAM.
- out_valid  out  1  lane_rdata valid (read transactions only).
- lane_rdata  out  LANES*DW  read data returned to the originating lanes.
- conflict  out  1  one-cycle pulse, aligned with bank_en, when any lane was dropped.
- conflict_mask  out  LANES  lanes dropped in that transaction, aligned with conflict.
- conflict_cnt  out  16  saturating count of transactions that had a conflict.
- cnt_clr  in  1  synchronous clear of conflict_cnt.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs go to 0; conflict_cnt goes to 0.
  - All pipeline valid bits and stored routing state are cleared.
  - In-flight reads are discarded; no out_valid is produced for them after reset is released.
- Request stage (edge t, in_valid=1):
  - For each bank b, the winner is the lowest-index lane l with lane_bank[l]==b.
  - Any other lane targeting b is a loser; losers are set in conflict_mask.
  - Outputs in cycle t+1:
    - bank_en[b]=1 for each bank with a winner.
    - bank_we[b]=in_we.
    - bank_addr/bank_wdata[b] = the winner's address/data.
  - Banks with no winner: bank_en=0, bank_we=0, addr=0, wdata=0.
  - conflict = |conflict_mask, registered in the same cycle as bank_en.
- in_valid=0 at edge t: in cycle t+1 all bank_en/bank_we are 0, addr/wdata are 0, conflict=0 and conflict_mask=0.
- Read return path (in_we=0):
  - The per-lane bank index and per-lane served mask (winners only) are delayed through an RD_LAT-deep shift pipeline.
  - bank_rdata is sampled in cycle t+1+RD_LAT.
  - In cycle t+2+RD_LAT: out_valid=1, and lane_rdata[l] = bank_rdata[lane_bank[l]] for served lanes, 0 for dropped lanes.
  - Total read latency is RD_LAT+2 cycles from the request edge.
- Write transactions never assert out_valid.
- In any cycle with out_valid=0, lane_rdata=0.
- Throughput:
  - Fully pipelined, one transaction per cycle, any mix of reads and writes.
  - No backpressure; up to RD_LAT+2 transactions in flight.
- conflict_cnt:
  - Increments by 1 on each cycle in which conflict is asserted.
  - Saturates at 16'hFFFF.
  - If cnt_clr and an increment occur in the same cycle, the result is 0 (clear wins).
- Permutation with all banks distinct (the normal NTT case): no conflict; all lanes are served.
- Out-of-range lane_bank values cannot occur (LANES is a power of 2).

Test Plan:
- Identity read, LANES=8, RD_LAT=2, BRAM model rdata = {bank,addr}: lane_bank[l]=l, lane_addr[l]=l+3, in_we=0.
  -> bank_addr[b]=b+3 at t+1; out_valid at t+4; lane_rdata[l]={l,l+3}; conflict=0.
- Bit-reverse permutation write then read: write lane l to bank rev3(l), wdata=100+l; read back with the same mapping.
  -> lane_rdata[l]=100+l for all l; bank_we=8'hFF in the write cycle only.
- Conflict: lanes 2 and 5 both target bank 3; the other lanes use distinct banks.
  -> bank_addr[3]=lane_addr[2]; conflict=1 and conflict_mask=8'b0010_0000 at t+1; lane_rdata[5]=0; conflict_cnt=1.
- Back-to-back R,W,R,idle,R: one request per cycle.
  -> exactly three out_valid pulses at request edge+4, data matching each read; no pulse for the write or the idle cycle.
- Reset mid-flight: assert rst_n=0 one cycle after a read request; release two cycles later.
  -> all outputs 0 immediately; no out_valid after release; the next read behaves normally.
- Counter: force conflict_cnt to 16'hFFFE, then apply three conflicting transactions.
  -> count is 16'hFFFF and holds.
  - cnt_clr concurrent with a conflict -> count = 0.

Source files
------------

// File: rtl/bank_xbar_pipe.sv
// Pipelined lane-to-bank crossbar for a multi-bank coefficient memory.
// Routes every lane to its target bank through a register stage, using fixed
// lowest-lane-wins priority. The routing of each read follows the BRAM latency
// so that read data goes back to the lanes that asked for it.
// Dropped lanes are reported and counted in a saturating counter.
module bank_xbar_pipe #(
    parameter int LANES  = 8,
    parameter int ADW    = 5,
    parameter int DW     = 32,
    parameter int RD_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic                      in_we,
    input  logic [LANES*ADW-1:0]      lane_addr,
    input  logic [LANES*$clog2(LANES)-1:0] lane_bank,
    input  logic [LANES*DW-1:0]       lane_wdata,
    output logic [LANES-1:0]          bank_en,
    output logic [LANES-1:0]          bank_we,
    output logic [LANES*ADW-1:0]      bank_addr,
    output logic [LANES*DW-1:0]       bank_wdata,
    input  logic [LANES*DW-1:0]       bank_rdata,
    output logic                      out_valid,
    output logic [LANES*DW-1:0]       lane_rdata,
    output logic                      conflict,
    output logic [LANES-1:0]          conflict_mask,
    output logic [15:0]               conflict_cnt,
    input  logic                      cnt_clr
);
    localparam int LW = $clog2(LANES);

    logic [LW-1:0]             win_lane [LANES];
    logic [LANES-1:0]          bank_hit;
    logic [LANES-1:0]          loser;

    logic [LANES-1:0]          bank_en_d, bank_we_d, bank_en_q, bank_we_q;
    logic [LANES*ADW-1:0]      bank_addr_d, bank_addr_q;
    logic [LANES*DW-1:0]       bank_wdata_d, bank_wdata_q;
    logic [LANES-1:0]          conflict_mask_d, conflict_mask_q;
    logic                      conflict_d, conflict_q;
    logic                      rd_req;

    // Read routing history: stage 0 sits beside the bank outputs, stage RD_LAT
    // lines up with the cycle in which bank_rdata is valid.
    logic [RD_LAT:0]                 pipe_vld_q;
    logic [RD_LAT:0][LANES*LW-1:0]   pipe_bank_q;
    logic [RD_LAT:0][LANES-1:0]      pipe_srv_q;

    logic                      out_valid_d, out_valid_q;
    logic [LANES*DW-1:0]       lane_rdata_d, lane_rdata_q;
    logic [15:0]               conflict_cnt_d, conflict_cnt_q;

    // Per-bank arbitration: scanning lanes top-down leaves the lowest-index requester as winner
    always_comb begin
        for (int b = 0; b < LANES; b++) begin
            bank_hit[b] = 1'b0;
            win_lane[b] = '0;
            for (int l = LANES - 1; l >= 0; l--) begin
                if (lane_bank[l*LW +: LW] == LW'(b)) begin
                    bank_hit[b] = 1'b1;
                    win_lane[b] = LW'(l);
                end
            end
        end
    end

    // A lane is dropped when any lower-index lane already claims the same bank
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            loser[l] = 1'b0;
            for (int j = 0; j < l; j++) begin
                if (lane_bank[j*LW +: LW] == lane_bank[l*LW +: LW]) begin
                    loser[l] = 1'b1;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_bank
            assign bank_en_d[gi] = in_valid & bank_hit[gi];
            assign bank_we_d[gi] = bank_en_d[gi] & in_we;
            assign bank_addr_d[gi*ADW +: ADW] =
                bank_en_d[gi] ? lane_addr[win_lane[gi]*ADW +: ADW] : '0;
            assign bank_wdata_d[gi*DW +: DW] =
                bank_en_d[gi] ? lane_wdata[win_lane[gi]*DW +: DW] : '0;
        end

        // Steer the registered bank data back to each served lane; dropped or idle lanes read 0
        for (gi = 0; gi < LANES; gi++) begin : g_ret
            logic [LW-1:0] src_bank;
            assign src_bank = pipe_bank_q[RD_LAT][gi*LW +: LW];
            assign lane_rdata_d[gi*DW +: DW] =
                (pipe_vld_q[RD_LAT] & pipe_srv_q[RD_LAT][gi]) ? bank_rdata[src_bank*DW +: DW] : '0;
        end
    endgenerate

    assign conflict_mask_d = in_valid ? loser : '0;
    assign conflict_d      = |conflict_mask_d;
    assign rd_req          = in_valid & ~in_we;
    assign out_valid_d     = pipe_vld_q[RD_LAT];

    // Saturating conflict counter; a clear overrides a same-cycle increment
    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (cnt_clr) begin
            conflict_cnt_d = '0;
        end else if (conflict_q && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    // Request stage registers: bank port drive and conflict report
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_en_q       <= '0;
            bank_we_q       <= '0;
            bank_addr_q     <= '0;
            bank_wdata_q    <= '0;
            conflict_q      <= 1'b0;
            conflict_mask_q <= '0;
        end else begin
            bank_en_q       <= bank_en_d;
            bank_we_q       <= bank_we_d;
            bank_addr_q     <= bank_addr_d;
            bank_wdata_q    <= bank_wdata_d;
            conflict_q      <= conflict_d;
            conflict_mask_q <= conflict_mask_d;
        end
    end

    // Read routing shift pipeline; reset drops every in-flight read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q  <= '0;
            pipe_bank_q <= '0;
            pipe_srv_q  <= '0;
        end else begin
            pipe_vld_q  <= {pipe_vld_q[RD_LAT-1:0], rd_req};
            pipe_bank_q <= {pipe_bank_q[RD_LAT-1:0], lane_bank};
            pipe_srv_q  <= {pipe_srv_q[RD_LAT-1:0], ~loser};
        end
    end

    // Return stage and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            lane_rdata_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            lane_rdata_q   <= lane_rdata_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign bank_en       = bank_en_q;
    assign bank_we       = bank_we_q;
    assign bank_addr     = bank_addr_q;
    assign bank_wdata    = bank_wdata_q;
    assign conflict      = conflict_q;
    assign conflict_mask = conflict_mask_q;
    assign out_valid     = out_valid_q;
    assign lane_rdata    = lane_rdata_q;
    assign conflict_cnt  = conflict_cnt_q;

endmodule

// File: tb/tb_bank_xbar_pipe.sv
// Bench for bank_xbar_pipe: directed test-plan steps followed by random traffic,
// all checked against a memory-level model of what each lane should see.
module tb_bank_xbar_pipe;
    localparam int LANES  = 8;
    localparam int ADW    = 5;
    localparam int DW     = 32;
    localparam int RD_LAT = 2;
    localparam int LW     = 3;
    localparam int DEPTH  = 1 << ADW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid, in_we, cnt_clr;
    logic [LANES*ADW-1:0] lane_addr;
    logic [LANES*LW-1:0]  lane_bank;
    logic [LANES*DW-1:0]  lane_wdata;
    logic [LANES-1:0]     bank_en, bank_we, conflict_mask;
    logic [LANES*ADW-1:0] bank_addr;
    logic [LANES*DW-1:0]  bank_wdata, bank_rdata, lane_rdata;
    logic                 out_valid, conflict;
    logic [15:0]          conflict_cnt;

    always #5 clk = ~clk;

    bank_xbar_pipe #(.LANES(LANES), .ADW(ADW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_we(in_we),
        .lane_addr(lane_addr), .lane_bank(lane_bank), .lane_wdata(lane_wdata),
        .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
        .bank_wdata(bank_wdata), .bank_rdata(bank_rdata), .out_valid(out_valid),
        .lane_rdata(lane_rdata), .conflict(conflict), .conflict_mask(conflict_mask),
        .conflict_cnt(conflict_cnt), .cnt_clr(cnt_clr)
    );

    // BRAM model: read-first, RD_LAT cycles; unwritten words read as {bank,addr};
    // non-enabled banks return junk so mistimed sampling shows up.
    logic [DW-1:0]       mem    [LANES][DEPTH];
    bit   [DEPTH-1:0]    wr_map [LANES];
    logic [LANES*DW-1:0] rd_stage [RD_LAT];
    assign bank_rdata = rd_stage[RD_LAT-1];

    always @(posedge clk) begin
        for (int b = 0; b < LANES; b++) begin
            int a;
            a = int'(bank_addr[b*ADW +: ADW]);
            if (bank_en[b]) begin
                rd_stage[0][b*DW +: DW] <= wr_map[b][a] ? mem[b][a] : DW'((b << ADW) | a);
                if (bank_we[b]) begin
                    mem[b][a]    <= bank_wdata[b*DW +: DW];
                    wr_map[b][a] <= 1'b1;
                end
            end else begin
                rd_stage[0][b*DW +: DW] <= $urandom;
            end
        end
        for (int k = 1; k < RD_LAT; k++) rd_stage[k] <= rd_stage[k-1];
    end

    // Reference model state
    typedef struct { int due; logic [LANES*DW-1:0] data; } rd_t;
    rd_t         exp_q[$];
    logic [DW-1:0] model_mem [LANES][DEPTH];
    int          cyc;
    bit          exp_conf;
    int          model_cnt;
    int          n_pass, n_fail, n_total;

    int            s_addr [LANES];
    int            s_bank [LANES];
    logic [DW-1:0] s_wdata[LANES];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".bank_en"}, bank_en, 0);
        chk({tag, ".bank_we"}, bank_we, 0);
        chk({tag, ".bank_addr"}, bank_addr, 0);
        chk({tag, ".bank_wdata"}, bank_wdata, 0);
        chk({tag, ".conflict"}, conflict, 0);
        chk({tag, ".conflict_mask"}, conflict_mask, 0);
        chk({tag, ".out_valid"}, out_valid, 0);
        chk({tag, ".lane_rdata"}, lane_rdata, 0);
        chk({tag, ".conflict_cnt"}, conflict_cnt, 0);
    endtask

    // One clock of traffic using s_addr/s_bank/s_wdata; checks every output after the edge
    task automatic step(input bit v, input bit we, input bit clr);
        int win[LANES];
        logic [LANES-1:0]     e_en, e_we, e_mask;
        logic [LANES*ADW-1:0] e_addr;
        logic [LANES*DW-1:0]  e_wd, rdat, e_rd;
        bit e_ov;
        int new_cnt;
        for (int l = 0; l < LANES; l++) begin
            lane_addr[l*ADW +: ADW] = ADW'(s_addr[l]);
            lane_bank[l*LW +: LW]   = LW'(s_bank[l]);
            lane_wdata[l*DW +: DW]  = s_wdata[l];
        end
        in_valid = v; in_we = we; cnt_clr = clr;

        for (int b = 0; b < LANES; b++) win[b] = -1;
        for (int l = 0; l < LANES; l++) if (win[s_bank[l]] < 0) win[s_bank[l]] = l;
        e_en = '0; e_we = '0; e_mask = '0; e_addr = '0; e_wd = '0; rdat = '0;
        if (v) begin
            for (int b = 0; b < LANES; b++) if (win[b] >= 0) begin
                e_en[b] = 1'b1;
                e_we[b] = we;
                e_addr[b*ADW +: ADW] = ADW'(s_addr[win[b]]);
                e_wd[b*DW +: DW]     = s_wdata[win[b]];
            end
            for (int l = 0; l < LANES; l++) e_mask[l] = (win[s_bank[l]] != l);
            if (!we) begin
                for (int l = 0; l < LANES; l++)
                    if (!e_mask[l]) rdat[l*DW +: DW] = model_mem[s_bank[l]][s_addr[l]];
                exp_q.push_back('{due: cyc + 1 + RD_LAT + 1, data: rdat});
            end else begin
                for (int b = 0; b < LANES; b++)
                    if (win[b] >= 0) model_mem[b][s_addr[win[b]]] = s_wdata[win[b]];
            end
        end
        if (clr) new_cnt = 0;
        else if (exp_conf && model_cnt < 16'hFFFF) new_cnt = model_cnt + 1;
        else new_cnt = model_cnt;

        @(posedge clk);
        cyc++;
        #1;
        exp_conf  = |e_mask;
        model_cnt = new_cnt;
        e_ov = 1'b0; e_rd = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e_ov = 1'b1; e_rd = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        chk("bank_en", bank_en, e_en);
        chk("bank_we", bank_we, e_we);
        chk("bank_addr", bank_addr, e_addr);
        chk("bank_wdata", bank_wdata, e_wd);
        chk("conflict", conflict, exp_conf);
        chk("conflict_mask", conflict_mask, e_mask);
        chk("conflict_cnt", conflict_cnt, model_cnt[15:0]);
        chk("out_valid", out_valid, e_ov);
        chk("lane_rdata", lane_rdata, e_rd);
        $display("cyc=%0d v=%0b we=%0b clr=%0b en=%h mask=%h cnt=%0d ov=%0b",
                 cyc, v, we, clr, bank_en, conflict_mask, conflict_cnt, out_valid);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    function automatic int rev3(input int x);
        return ((x & 1) << 2) | (x & 2) | ((x >> 2) & 1);
    endfunction

    task automatic set_perm_random();
        for (int l = 0; l < LANES; l++) s_bank[l] = l;
        for (int i = LANES - 1; i > 0; i--) begin
            int j, t;
            j = $urandom_range(0, i);
            t = s_bank[i]; s_bank[i] = s_bank[j]; s_bank[j] = t;
        end
    endtask

    task automatic set_conflict_pattern();
        int cb[LANES] = '{0, 1, 3, 2, 4, 3, 5, 6};
        for (int l = 0; l < LANES; l++) begin
            s_bank[l]  = cb[l];
            s_addr[l]  = (l * 7 + 1) % DEPTH;
            s_wdata[l] = 32'hC000 + l;
        end
    endtask

    initial begin
        n_pass = 0; n_fail = 0; n_total = 0; cyc = 0;
        exp_conf = 1'b0; model_cnt = 0;
        in_valid = 1'b0; in_we = 1'b0; cnt_clr = 1'b0;
        lane_addr = '0; lane_bank = '0; lane_wdata = '0;
        for (int b = 0; b < LANES; b++)
            for (int a = 0; a < DEPTH; a++) model_mem[b][a] = DW'((b << ADW) | a);
        for (int l = 0; l < LANES; l++) begin s_addr[l] = 0; s_bank[l] = l; s_wdata[l] = '0; end

        // Reset state
        #1;
        chk_all_zero("reset");
        idle(2);
        rst_n = 1'b1;

        // Identity read: lane l -> bank l, address l+3
        for (int l = 0; l < LANES; l++) begin s_bank[l] = l; s_addr[l] = l + 3; end
        step(1'b1, 1'b0, 1'b0);
        idle(RD_LAT + 2);

        // Bit-reverse permutation write then read back
        for (int l = 0; l < LANES; l++) begin
            s_bank[l] = rev3(l); s_addr[l] = 9; s_wdata[l] = 100 + l;
        end
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        idle(RD_LAT + 2);

        // Conflict: lanes 2 and 5 both target bank 3
        set_conflict_pattern();
        step(1'b1, 1'b0, 1'b0);
        idle(RD_LAT + 2);

        // Back-to-back R, W, R, idle, R
        for (int l = 0; l < LANES; l++) begin s_bank[l] = l; s_addr[l] = 20; s_wdata[l] = 32'hAB00 + l; end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        set_perm_random();
        step(1'b1, 1'b0, 1'b0);
        idle(RD_LAT + 2);

        // Reset mid-flight: assert one cycle after a read request, release two cycles later
        for (int l = 0; l < LANES; l++) begin s_bank[l] = l; s_addr[l] = l; end
        step(1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        exp_q.delete();
        exp_conf = 1'b0; model_cnt = 0;
        idle(2);
        rst_n = 1'b1;
        idle(RD_LAT + 2);
        step(1'b1, 1'b0, 1'b0);
        idle(RD_LAT + 2);

        // Random traffic: permutations and colliding maps, mixed reads/writes, occasional clear
        for (int n = 0; n < 80; n++) begin
            bit v, we, clr;
            v   = ($urandom_range(0, 9) != 0);
            we  = $urandom_range(0, 1);
            clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1)) set_perm_random();
            else for (int l = 0; l < LANES; l++) s_bank[l] = $urandom_range(0, LANES - 1);
            for (int l = 0; l < LANES; l++) begin
                s_addr[l]  = $urandom_range(0, DEPTH - 1);
                s_wdata[l] = $urandom;
            end
            step(v, we, clr);
        end
        idle(RD_LAT + 2);

        // Counter saturation from 16'hFFFE
        force dut.conflict_cnt_q = 16'hFFFE;
        #1;
        release dut.conflict_cnt_q;
        model_cnt = 16'hFFFE;
        set_conflict_pattern();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        idle(2);
        // Clear concurrent with a conflict: clear wins
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
